// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional feature macro used by the top: PC_ALIGN_CHECK_EN.
package pc_pkg;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    IDLE  = 3'd1,
    BUSY  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } pc_state_e;

  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// Program counter storage: XLEN-bit register with load enable and
// synchronous active-high reset to the reset vector.
module pc_reg
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] q_r;

  // Hold the PC; reset wins over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VECTOR;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the program counter and issues one instruction fetch
// at a time, dropping responses made stale by a trap or redirect.
// Optional feature: define PC_ALIGN_CHECK_EN to turn misaligned redirects
// into a trap to trap_vector with a one-cycle misalign_err pulse; without it
// redirect_target[1:0] is forced to zero and misalign_err stays 0.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_err
);

  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(2'b11));
  localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);

  pc_state_e       state_r, state_nx;
  logic            req_r, req_nx;
  logic [XLEN-1:0] addr_r, addr_nx;
  logic [XLEN-1:0] pc_out_r, pc_out_nx;
  logic            pc_valid_r, pc_valid_nx;
  logic            mis_r, mis_nx;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            pc_load;

  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic            jump_valid;
  logic [XLEN-1:0] jump_tgt;
  logic            jump_mis;

  pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc_q)
  );

  // Resolve the trap/redirect target with trap taking priority.
  always_comb begin
    trap_tgt  = trap_vector & WORD_MASK;
    redir_tgt = redirect_target & WORD_MASK;
`ifdef PC_ALIGN_CHECK_EN
    redir_bad = (redirect_target[1:0] != 2'b00);
`else
    redir_bad = 1'b0;
`endif
    jump_valid = trap_valid | redirect_valid;
    jump_mis   = 1'b0;
    if (trap_valid) begin
      jump_tgt = trap_tgt;
    end else if (redirect_valid && redir_bad) begin
      // A misaligned redirect is not taken; it behaves as a trap.
      jump_tgt = trap_tgt;
      jump_mis = 1'b1;
    end else begin
      jump_tgt = redir_tgt;
    end
  end

  // Next-state, next-PC and next-output decisions for the fetch FSM.
  always_comb begin
    state_nx    = state_r;
    req_nx      = req_r;
    addr_nx     = addr_r;
    pc_out_nx   = pc_out_r;
    pc_valid_nx = 1'b0;
    mis_nx      = 1'b0;
    pc_load     = 1'b0;
    pc_d        = pc_q;
    case (state_r)
      BOOT: begin
        req_nx   = 1'b0;
        state_nx = IDLE;
      end
      IDLE: begin
        if (jump_valid) begin
          pc_load = 1'b1;
          pc_d    = jump_tgt;
          mis_nx  = jump_mis;
        end else if (halt) begin
          state_nx = HALT;
        end else if (stall) begin
          state_nx = IDLE;
        end else begin
          req_nx   = 1'b1;
          addr_nx  = pc_q;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (jump_valid) begin
          pc_load = 1'b1;
          pc_d    = jump_tgt;
          mis_nx  = jump_mis;
          if (imem_ack) begin
            // Response arrives with the jump: drop it, nothing left in flight.
            req_nx   = 1'b0;
            state_nx = IDLE;
          end else begin
            // Request must stay stable until acked; its data will be discarded.
            state_nx = DRAIN;
          end
        end else if (imem_ack) begin
          pc_valid_nx = 1'b1;
          pc_out_nx   = addr_r;
          pc_load     = 1'b1;
          pc_d        = addr_r + STEP;
          if (!stall && !halt) begin
            addr_nx = addr_r + STEP;
          end else begin
            req_nx   = 1'b0;
            state_nx = halt ? HALT : IDLE;
          end
        end else begin
          // Waiting for the memory: hold the request regardless of stall.
          state_nx = BUSY;
        end
      end
      DRAIN: begin
        if (jump_valid) begin
          pc_load = 1'b1;
          pc_d    = jump_tgt;
          mis_nx  = jump_mis;
        end else begin
          pc_load = 1'b0;
        end
        if (imem_ack) begin
          req_nx   = 1'b0;
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      HALT: begin
        req_nx = 1'b0;
        if (trap_valid) begin
          pc_load  = 1'b1;
          pc_d     = trap_tgt;
          state_nx = IDLE;
        end else begin
          state_nx = HALT;
        end
      end
      default: begin
        req_nx   = 1'b0;
        state_nx = BOOT;
      end
    endcase
  end

  // State and registered outputs; reset abandons any outstanding fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= BOOT;
      req_r      <= 1'b0;
      addr_r     <= RESET_VECTOR;
      pc_out_r   <= RESET_VECTOR;
      pc_valid_r <= 1'b0;
      mis_r      <= 1'b0;
    end else begin
      state_r    <= state_nx;
      req_r      <= req_nx;
      addr_r     <= addr_nx;
      pc_out_r   <= pc_out_nx;
      pc_valid_r <= pc_valid_nx;
      mis_r      <= mis_nx;
    end
  end

  assign imem_req     = req_r;
  assign imem_addr    = addr_r;
  assign pc_out       = pc_out_r;
  assign pc_valid     = pc_valid_r;
  assign misalign_err = mis_r;

endmodule
